// File: rtl/acc_row_drain_if.sv
// Row-in / beat-out handshake bundle for acc_row_drain.
// master drives rows and out_ready; slave is the drain block.
interface acc_row_drain_if #(
    parameter int DW    = 32,
    parameter int DP    = 56,
    parameter int OW    = 8,
    parameter int LANES = 8
);
    localparam int BEATS = DP / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic                  row_valid_i;
    logic                  row_ready_o;
    logic [DW*DP-1:0]      row_data_i;
    logic [4:0]            shift_i;
    logic                  relu_en_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [OW*LANES-1:0]   out_data_o;
    logic [BW-1:0]         out_beat_o;
    logic                  out_last_o;

    modport master (
        output row_valid_i, row_data_i, shift_i, relu_en_i, out_ready_i,
        input  row_ready_o, out_valid_o, out_data_o, out_beat_o, out_last_o
    );

    modport slave (
        input  row_valid_i, row_data_i, shift_i, relu_en_i, out_ready_i,
        output row_ready_o, out_valid_o, out_data_o, out_beat_o, out_last_o
    );
endinterface

// File: rtl/acc_row_drain.sv
// Quantizes one accumulated row (ReLU, rounding shift, saturate)
// and streams it out as LANES-wide beats under valid/ready.
module acc_row_drain #(
    parameter int DW    = 32,
    parameter int DP    = 56,
    parameter int OW    = 8,
    parameter int LANES = 8
) (
    input  logic            clk,
    input  logic            rst,
    acc_row_drain_if.slave  bus
);
    localparam int BEATS = DP / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BEATW = OW * LANES;

    localparam logic [BW-1:0]       LAST_BEAT = BW'(BEATS - 1);
    localparam logic signed [DW:0]  SAT_HI    = (DW+1)'((1 << (OW - 1)) - 1);
    localparam logic signed [DW:0]  SAT_LO    = ~SAT_HI;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                         state_q, state_d;
    logic [BW-1:0]                  beat_q, beat_d;
    logic [BEATS-1:0][BEATW-1:0]    buf_q, buf_d;

    logic out_valid;
    logic at_last;
    logic out_hs;
    logic row_ready;
    logic accept;

    // One extra bit of headroom keeps x + 2^(sh-1) from overflowing.
    function automatic logic [OW-1:0] quantize(
        input logic [DW-1:0] x,
        input logic [4:0]    sh,
        input logic          relu
    );
        logic signed [DW:0] v;
        logic signed [DW:0] rnd;
        v   = $signed({x[DW-1], x});
        rnd = '0;
        if (relu && v < 0) v = '0;
        if (sh != 5'd0) begin
            rnd = (DW+1)'(1) << (sh - 5'd1);
            v   = (v + rnd) >>> sh;
        end
        if (v > SAT_HI) return SAT_HI[OW-1:0];
        if (v < SAT_LO) return SAT_LO[OW-1:0];
        return v[OW-1:0];
    endfunction

    always_comb begin
        out_valid = (state_q == SEND);
        at_last   = (beat_q == LAST_BEAT);
        out_hs    = out_valid & bus.out_ready_i;
        row_ready = (state_q == IDLE) | (out_hs & at_last);
        accept    = bus.row_valid_i & row_ready;

        state_d = state_q;
        beat_d  = beat_q;
        buf_d   = buf_q;

        // The three arms are exclusive: mid-row beats keep row_ready low.
        unique case (1'b1)
            accept: begin
                state_d = SEND;
                beat_d  = '0;
                for (int i = 0; i < DP; i++) begin
                    buf_d[i / LANES][(i % LANES) * OW +: OW] =
                        quantize(bus.row_data_i[DW*i +: DW],
                                 bus.shift_i, bus.relu_en_i);
                end
            end
            (out_hs & !at_last): begin
                beat_d = beat_q + 1'b1;
            end
            (out_hs & at_last & !accept): begin
                state_d = IDLE;
                beat_d  = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            buf_q   <= buf_d;
        end
    end

    assign bus.row_ready_o = row_ready;
    assign bus.out_valid_o = out_valid;
    assign bus.out_data_o  = out_valid ? buf_q[beat_q] : '0;
    assign bus.out_beat_o  = beat_q;
    assign bus.out_last_o  = out_valid & at_last;
endmodule

// File: tb/tb_acc_row_drain.sv
// Bench for acc_row_drain: queue-based reference of expected beats,
// randomized rows and backpressure, plus directed rounding/reset cases.
module tb_acc_row_drain;
    localparam int DW    = 32;
    localparam int DP    = 56;
    localparam int OW    = 8;
    localparam int LANES = 8;
    localparam int BEATS = DP / LANES;
    localparam longint QMAX = (longint'(1) << (OW - 1)) - 1;
    localparam longint QMIN = -(longint'(1) << (OW - 1));

    typedef struct {
        logic [OW*LANES-1:0] data;
        int                  beat;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    bit   rnd_mode = 1'b0;

    beat_t               exp_q[$];
    bit                  stall = 1'b0;
    logic [OW*LANES-1:0] stall_data;
    int                  stall_beat;

    acc_row_drain_if #(.DW(DW), .DP(DP), .OW(OW), .LANES(LANES)) bus();

    acc_row_drain #(.DW(DW), .DP(DP), .OW(OW), .LANES(LANES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Round-half-up division by 2^sh using floor semantics, then clamp.
    function automatic logic [OW-1:0] q_model(input longint x, input int sh,
                                              input bit re);
        longint y, d, q;
        if (re && x < 0) x = 0;
        if (sh > 0) begin
            d = longint'(1) << sh;
            y = x + d / 2;
            q = y / d;
            if (y < 0 && q * d != y) q = q - 1;
        end else begin
            q = x;
        end
        if (q > QMAX) q = QMAX;
        if (q < QMIN) q = QMIN;
        return q[OW-1:0];
    endfunction

    task automatic push_row(input logic [DW*DP-1:0] d, input int sh,
                            input bit re);
        beat_t  e;
        longint x;
        for (int b = 0; b < BEATS; b++) begin
            e.beat = b;
            e.data = '0;
            for (int l = 0; l < LANES; l++) begin
                x = longint'($signed(d[DW*(b*LANES+l) +: DW]));
                e.data[OW*l +: OW] = q_model(x, sh, re);
            end
            exp_q.push_back(e);
        end
    endtask

    always @(posedge clk) begin
        #1;
        bus.out_ready_i = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            stall = 1'b0;
        end else begin
            chk("row_ready", 64'(bus.row_ready_o),
                64'((exp_q.size() == 0) ||
                    (exp_q.size() == 1 && bus.out_ready_i)));
            chk("out_valid", 64'(bus.out_valid_o), 64'(exp_q.size() != 0));
            if (bus.out_valid_o && exp_q.size() != 0) begin
                chk("out_data", 64'(bus.out_data_o), 64'(exp_q[0].data));
                chk("out_beat", 64'(bus.out_beat_o), 64'(exp_q[0].beat));
                chk("out_last", 64'(bus.out_last_o),
                    64'(exp_q[0].beat == BEATS - 1));
            end
            if (stall) begin
                chk("stall_data", 64'(bus.out_data_o), 64'(stall_data));
                chk("stall_beat", 64'(bus.out_beat_o), 64'(stall_beat));
            end
            stall      = bus.out_valid_o && !bus.out_ready_i;
            stall_data = bus.out_data_o;
            stall_beat = int'(bus.out_beat_o);
            if (bus.out_valid_o && bus.out_ready_i && exp_q.size() != 0)
                void'(exp_q.pop_front());
            if (bus.row_valid_i && bus.row_ready_o)
                push_row(bus.row_data_i, int'(bus.shift_i), bus.relu_en_i);
        end
    end

    task automatic send_row(input logic [DW*DP-1:0] d, input logic [4:0] sh,
                            input logic re);
        bit ok;
        ok = 1'b0;
        bus.row_data_i  = d;
        bus.shift_i     = sh;
        bus.relu_en_i   = re;
        bus.row_valid_i = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = bus.row_ready_o;
            @(posedge clk);
            #1;
        end
        bus.row_valid_i = 1'b0;
        bus.row_data_i  = ~d;
        bus.shift_i     = 5'($urandom);
        bus.relu_en_i   = 1'($urandom);
        chk("row_accept_timeout", 64'(ok), 64'd1);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 1000 && !done; n++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !bus.out_valid_o;
        end
        chk("drain_timeout", 64'(done), 64'd1);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW*DP-1:0] rand_row();
        logic [DW*DP-1:0] d;
        int               v;
        for (int i = 0; i < DP; i++) begin
            case ($urandom_range(0, 2))
                0:       v = int'($urandom);
                1:       v = int'($urandom_range(0, 600)) - 300;
                default: v = int'($urandom_range(0, 8000)) - 4000;
            endcase
            d[DW*i +: DW] = DW'(v);
        end
        return d;
    endfunction

    function automatic logic [DW*DP-1:0] ramp_row();
        logic [DW*DP-1:0] d;
        for (int i = 0; i < DP; i++) d[DW*i +: DW] = DW'(16 * i);
        return d;
    endfunction

    initial begin
        logic [DW*DP-1:0] d;
        bit               hit;

        bus.row_valid_i = 1'b0;
        bus.row_data_i  = '0;
        bus.shift_i     = '0;
        bus.relu_en_i   = 1'b0;
        bus.out_ready_i = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(bus.out_valid_o), 64'd0);
        chk("rst_data",  64'(bus.out_data_o),  64'd0);
        chk("rst_beat",  64'(bus.out_beat_o),  64'd0);
        chk("rst_last",  64'(bus.out_last_o),  64'd0);
        rst = 1'b0;
        #1;
        chk("idle_ready", 64'(bus.row_ready_o), 64'd1);

        chk("pin_24",     64'(q_model(24, 4, 0)),      64'h02);
        chk("pin_23",     64'(q_model(23, 4, 0)),      64'h01);
        chk("pin_m24",    64'(q_model(-24, 4, 0)),     64'hff);
        chk("pin_8",      64'(q_model(8, 4, 0)),       64'h01);
        chk("pin_7",      64'(q_model(7, 4, 0)),       64'h00);
        chk("pin_sat_hi", 64'(q_model(100000, 0, 0)),  64'h7f);
        chk("pin_sat_lo", 64'(q_model(-100000, 0, 0)), 64'h80);
        chk("pin_relu_n", 64'(q_model(-5, 4, 1)),      64'h00);
        chk("pin_relu_s", 64'(q_model(5000, 4, 1)),    64'h7f);
        chk("pin_relu_p", 64'(q_model(40, 4, 1)),      64'h03);
        chk("pin_m5",     64'(q_model(-5, 4, 0)),      64'h00);
        chk("pin_m40",    64'(q_model(-40, 4, 0)),     64'hfe);

        @(posedge clk);
        #1;
        send_row(ramp_row(), 5'd4, 1'b0);
        chk("first_valid", 64'(bus.out_valid_o), 64'd1);
        chk("ramp_beat0",  64'(bus.out_data_o),  64'h0706050403020100);
        wait_idle();

        d = rand_row();
        d[DW*0 +: DW] = DW'(24);
        d[DW*1 +: DW] = DW'(23);
        d[DW*2 +: DW] = DW'(-24);
        d[DW*3 +: DW] = DW'(8);
        d[DW*4 +: DW] = DW'(7);
        send_row(d, 5'd4, 1'b0);
        d = rand_row();
        d[DW*0 +: DW] = DW'(100000);
        d[DW*1 +: DW] = DW'(-100000);
        send_row(d, 5'd0, 1'b0);
        d = rand_row();
        d[DW*0 +: DW] = DW'(-5);
        d[DW*1 +: DW] = DW'(5000);
        d[DW*2 +: DW] = DW'(40);
        send_row(d, 5'd4, 1'b1);
        d = rand_row();
        d[DW*0 +: DW] = DW'(-5);
        d[DW*1 +: DW] = DW'(-40);
        send_row(d, 5'd4, 1'b0);
        wait_idle();

        rnd_mode = 1'b1;
        for (int r = 0; r < 24; r++) begin
            send_row(rand_row(), 5'($urandom_range(0, 31)),
                     1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 5)) @(posedge clk);
            #1;
        end
        wait_idle();

        rnd_mode = 1'b0;
        @(posedge clk);
        #1;
        send_row(rand_row(), 5'd3, 1'b0);
        hit = 1'b0;
        for (int n = 0; n < 50 && !hit; n++) begin
            @(negedge clk);
            hit = bus.out_valid_o && bus.out_ready_i &&
                  (bus.out_beat_o == 3'd3);
        end
        chk("beat3_timeout", 64'(hit), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_valid", 64'(bus.out_valid_o), 64'd0);
        chk("midrst_data",  64'(bus.out_data_o),  64'd0);
        chk("midrst_beat",  64'(bus.out_beat_o),  64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_row(ramp_row(), 5'd4, 1'b0);
        chk("restart_valid", 64'(bus.out_valid_o), 64'd1);
        chk("restart_beat",  64'(bus.out_beat_o),  64'd0);
        chk("restart_data",  64'(bus.out_data_o),  64'h0706050403020100);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
